// File: rtl/flit_packetizer.sv
// flit_packetizer: injection-side writer for a router input-port FIFO.
// Turns a packet request (destination + payload length) and a stream of
// payload words into one header flit followed by body flits and a tail flit.
// Flit type is one-hot in the top three bits: 001 header, 010 body, 100 tail.
module flit_packetizer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2,
   parameter int LEN_WIDTH  = 8,
   parameter int SRC_ADDR   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_dst,
   input  logic [LEN_WIDTH-1:0]    req_len,
   input  logic                    data_valid,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic                    data_ready,
   input  logic                    full,
   output logic                    wr_en,
   output logic [DATA_WIDTH+2:0]   flit_out,
   output logic                    busy,
   output logic                    pkt_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

   localparam logic [2:0]            TYPE_HEAD = 3'b001;
   localparam logic [2:0]            TYPE_BODY = 3'b010;
   localparam logic [2:0]            TYPE_TAIL = 3'b100;
   localparam logic [ADDR_WIDTH-1:0] SRC_FIELD = ADDR_WIDTH'(SRC_ADDR);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] dst_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [DATA_WIDTH-1:0] hdr;
   logic                  is_tail;
   logic                  tail_written;

   // The flit being offered is the tail when only one payload word is left.
   assign is_tail = (remaining == LEN_ONE);
   assign busy    = (state != IDLE);

   // Assemble the header word: dst, source node, length, upper bits zero.
   always_comb begin
      hdr = '0;
      hdr[ADDR_WIDTH-1:0]                         = dst_q;
      hdr[2*ADDR_WIDTH-1:ADDR_WIDTH]              = SRC_FIELD;
      hdr[2*ADDR_WIDTH+LEN_WIDTH-1:2*ADDR_WIDTH]  = len_q;
   end

   // Next-state and FIFO-side outputs, all derived from registered state.
   always_comb begin
      // NOTE: every output gets a default before the case so no path through
      // the block leaves a signal unassigned, which would infer a latch.
      state_nxt    = state;
      req_ready    = 1'b0;
      data_ready   = 1'b0;
      wr_en        = 1'b0;
      flit_out     = '0;
      tail_written = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = HEADER;
         end
         HEADER: begin
            flit_out = {TYPE_HEAD, hdr};
            wr_en    = ~full;
            if (!full) state_nxt = PAYLOAD;
         end
         PAYLOAD: begin
            // Ready reflects only FIFO space so the source may wait on it
            // without forming a loop through data_valid.
            data_ready   = ~full;
            wr_en        = data_valid & ~full;
            flit_out     = {(is_tail ? TYPE_TAIL : TYPE_BODY), data_in};
            tail_written = wr_en & is_tail;
            if (tail_written) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, latched request fields, payload countdown and completion pulse.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from the
      // pre-edge values, so ordering inside this block does not matter.
      if (rst) begin
         state     <= IDLE;
         dst_q     <= '0;
         len_q     <= '0;
         remaining <= '0;
         pkt_done  <= 1'b0;
      end else begin
         state    <= state_nxt;
         pkt_done <= tail_written;
         if (state == IDLE && req_valid) begin
            dst_q <= req_dst;
            // A zero-length request still carries one word, sent as the tail.
            len_q <= (req_len == '0) ? LEN_ONE : req_len;
         end
         if (state == HEADER && !full) begin
            remaining <= len_q;
         end else if (state == PAYLOAD && wr_en) begin
            remaining <= remaining - LEN_ONE;
         end
      end
   end

endmodule

// File: tb/tb_flit_packetizer.sv
// tb_flit_packetizer: directed self-checking bench for flit_packetizer.
// Inputs change 2 time units after each rising edge and outputs are checked
// 1 unit later; a negedge monitor logs every flit the FIFO would accept.
module tb_flit_packetizer;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_dst;
   logic [7:0]  req_len;
   logic        data_valid;
   logic [31:0] data_in;
   logic        data_ready;
   logic        full;
   logic        wr_en;
   logic [34:0] flit_out;
   logic        busy;
   logic        pkt_done;

   int          tests = 0;
   int          fails = 0;
   logic [34:0] wlog[$];
   logic        wr_full_seen = 1'b0;

   flit_packetizer #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (2),
      .LEN_WIDTH  (8),
      .SRC_ADDR   (0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_dst    (req_dst),
      .req_len    (req_len),
      .data_valid (data_valid),
      .data_in    (data_in),
      .data_ready (data_ready),
      .full       (full),
      .wr_en      (wr_en),
      .flit_out   (flit_out),
      .busy       (busy),
      .pkt_done   (pkt_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record each accepted flit and any write attempted against a full FIFO.
   always @(negedge clk) begin
      if (!rst && wr_en) wlog.push_back(flit_out);
      if (wr_en && full) wr_full_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [34:0] wl(input int i);
      return (i < wlog.size()) ? wlog[i] : 'x;
   endfunction

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_dst = '0; req_len = '0;
      data_valid = 1'b0; data_in = '0; full = 1'b0;

      // Reset state
      nxt(); nxt(); #1;
      check("rst_req_ready",  req_ready,  1);
      check("rst_data_ready", data_ready, 0);
      check("rst_wr_en",      wr_en,      0);
      check("rst_flit_out",   flit_out,   0);
      check("rst_busy",       busy,       0);
      check("rst_pkt_done",   pkt_done,   0);
      rst = 1'b0;

      // Basic packet: dst=3, len=2, words 0xA, 0xB
      nxt(); wlog.delete();
      req_valid = 1; req_dst = 2'd3; req_len = 8'd2; data_valid = 1; data_in = 32'hA; #1;
      check("t1_accept_ready", req_ready, 1);
      check("t1_accept_wr",    wr_en,     0);
      nxt(); req_valid = 0; #1;
      check("t1_hdr_wr",    wr_en,      1);
      check("t1_hdr_flit",  flit_out,   {3'b001, 32'h0000_0023});
      check("t1_hdr_busy",  busy,       1);
      check("t1_hdr_rdy",   req_ready,  0);
      check("t1_hdr_dr",    data_ready, 0);
      nxt(); #1;
      check("t1_body_wr",   wr_en,      1);
      check("t1_body_flit", flit_out,   {3'b010, 32'h0000_000A});
      check("t1_body_dr",   data_ready, 1);
      nxt(); data_in = 32'hB; #1;
      check("t1_tail_wr",   wr_en,      1);
      check("t1_tail_flit", flit_out,   {3'b100, 32'h0000_000B});
      nxt(); data_valid = 0; #1;
      check("t1_done",      pkt_done,   1);
      check("t1_idle_busy", busy,       0);
      check("t1_idle_wr",   wr_en,      0);
      check("t1_idle_rdy",  req_ready,  1);
      nxt(); #1;
      check("t1_done_once", pkt_done,   0);
      check("t1_nwrites",   35'(wlog.size()), 3);

      // Zero-length request: header says len=1, single word goes as tail
      nxt(); wlog.delete();
      req_valid = 1; req_dst = 2'd1; req_len = 8'd0; data_valid = 1; data_in = 32'hC; #1;
      nxt(); req_valid = 0; #1;
      check("t2_hdr_flit",  flit_out, {3'b001, 32'h0000_0011});
      check("t2_hdr_wr",    wr_en,    1);
      nxt(); #1;
      check("t2_tail_flit", flit_out, {3'b100, 32'h0000_000C});
      check("t2_tail_wr",   wr_en,    1);
      nxt(); data_valid = 0; #1;
      check("t2_done",      pkt_done, 1);
      check("t2_nwrites",   35'(wlog.size()), 2);

      // Full held 5 cycles in HEADER and again mid-PAYLOAD: dst=2, len=3
      nxt(); wlog.delete();
      req_valid = 1; req_dst = 2'd2; req_len = 8'd3; full = 1; data_valid = 1; data_in = 32'h1; #1;
      nxt(); req_valid = 0; #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin nxt(); #1; end
         check("t3_hstall_wr", wr_en,      0);
         check("t3_hstall_dr", data_ready, 0);
         check("t3_hstall_bz", busy,       1);
      end
      nxt(); full = 0; #1;
      check("t3_hdr_wr",   wr_en,    1);
      check("t3_hdr_flit", flit_out, {3'b001, 32'h0000_0032});
      nxt(); #1;
      check("t3_b1_flit",  flit_out, {3'b010, 32'h0000_0001});
      nxt(); data_in = 32'h2; full = 1; #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin nxt(); #1; end
         check("t3_pstall_wr", wr_en,      0);
         check("t3_pstall_dr", data_ready, 0);
      end
      nxt(); full = 0; #1;
      check("t3_b2_flit",  flit_out, {3'b010, 32'h0000_0002});
      nxt(); data_in = 32'h3; #1;
      check("t3_tail_flit", flit_out, {3'b100, 32'h0000_0003});
      nxt(); data_valid = 0; #1;
      check("t3_done",     pkt_done, 1);
      check("t3_nwrites",  35'(wlog.size()), 4);
      check("t3_log0",     wl(0), {3'b001, 32'h0000_0032});
      check("t3_log1",     wl(1), {3'b010, 32'h0000_0001});
      check("t3_log2",     wl(2), {3'b010, 32'h0000_0002});
      check("t3_log3",     wl(3), {3'b100, 32'h0000_0003});

      // data_valid toggling with len=4, dst=0
      nxt(); wlog.delete();
      req_valid = 1; req_dst = 2'd0; req_len = 8'd4; data_valid = 0; #1;
      nxt(); req_valid = 0; #1;
      check("t4_hdr_wr", wr_en, 1);
      for (int k = 0; k < 8; k++) begin
         nxt();
         data_valid = (k % 2 == 0);
         data_in    = 32'h11 * (k / 2 + 1);
         #1;
         check("t4_wr", wr_en,      data_valid);
         check("t4_dr", data_ready, (k < 7) ? 1'b1 : 1'b0);
      end
      check("t4_done",    pkt_done, 1);
      check("t4_nwrites", 35'(wlog.size()), 5);
      check("t4_log0",    wl(0), {3'b001, 32'h0000_0040});
      check("t4_log1",    wl(1), {3'b010, 32'h0000_0011});
      check("t4_log2",    wl(2), {3'b010, 32'h0000_0022});
      check("t4_log3",    wl(3), {3'b010, 32'h0000_0033});
      check("t4_log4",    wl(4), {3'b100, 32'h0000_0044});

      // Back-to-back requests with req_valid held: dst=1, len=1
      nxt(); wlog.delete(); data_valid = 0;
      req_valid = 1; req_dst = 2'd1; req_len = 8'd1; data_valid = 1; data_in = 32'h55; #1;
      check("t5_acc1_rdy", req_ready, 1);
      nxt(); #1;
      check("t5_hdr1_wr",   wr_en,     1);
      check("t5_hdr1_flit", flit_out,  {3'b001, 32'h0000_0011});
      check("t5_hdr1_rdy",  req_ready, 0);
      nxt(); #1;
      check("t5_tail1",     flit_out,  {3'b100, 32'h0000_0055});
      check("t5_tail1_rdy", req_ready, 0);
      nxt(); #1;
      check("t5_gap_wr",    wr_en,     0);
      check("t5_gap_rdy",   req_ready, 1);
      check("t5_gap_done",  pkt_done,  1);
      nxt(); req_valid = 0; #1;
      check("t5_hdr2_wr",   wr_en,     1);
      check("t5_hdr2_flit", flit_out,  {3'b001, 32'h0000_0011});
      nxt(); #1;
      check("t5_tail2",     flit_out,  {3'b100, 32'h0000_0055});
      nxt(); data_valid = 0; #1;
      check("t5_done2",     pkt_done,  1);
      check("t5_nwrites",   35'(wlog.size()), 4);

      // Reset during the second body flit of a len=5 packet, dst=3
      nxt(); wlog.delete();
      req_valid = 1; req_dst = 2'd3; req_len = 8'd5; data_valid = 1; data_in = 32'h61; #1;
      nxt(); req_valid = 0; #1;
      check("t6_hdr_flit", flit_out, {3'b001, 32'h0000_0053});
      nxt(); #1;
      check("t6_b1_flit",  flit_out, {3'b010, 32'h0000_0061});
      nxt(); data_in = 32'h62; rst = 1; #1;
      nxt(); rst = 0; #1;
      check("t6_rst_busy", busy,      0);
      check("t6_rst_wr",   wr_en,     0);
      check("t6_rst_rdy",  req_ready, 1);
      check("t6_rst_done", pkt_done,  0);
      check("t6_rst_dr",   data_ready, 0);
      nxt(); nxt(); #1;
      check("t6_stay_wr",  wr_en,     0);
      check("t6_stay_bz",  busy,      0);
      check("t6_nwrites",  35'(wlog.size()), 2);
      check("t6_log1",     wl(1), {3'b010, 32'h0000_0061});
      data_valid = 0;

      check("never_wr_when_full", wr_full_seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/flit_packetizer.md
Name: flit_packetizer

Overview:
- Injection-side writer for a router input-port FIFO.
- Accepts a packet request (destination plus payload length) and a stream of payload words.
- Emits one header flit, then body flits, then a tail flit into the FIFO, using one-hot flit_type encoding: 001 header, 010 body, 100 tail.
- Sits between a local traffic source / network interface and the router input FIFO, honouring the FIFO's full flag. It produces the packets whose tail flit re-arms the FIFO's read side.

Parameters:
- DATA_WIDTH, 32, payload bits per flit.
- ADDR_WIDTH, 2, node address width (2x2 mesh).
- LEN_WIDTH, 8, payload-flit count width.
- SRC_ADDR, 0, this node's address, inserted in every header.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_dst  in  ADDR_WIDTH  destination address
- req_len  in  LEN_WIDTH  payload flit count (body + tail)
- data_valid  in  1  payload word valid
- data_in  in  DATA_WIDTH  payload word
- data_ready  out  1  payload word consumed when data_valid & data_ready
- full  in  1  FIFO full flag
- wr_en  out  1  FIFO write strobe
- flit_out  out  3+DATA_WIDTH  {flit_type[2:0], payload[DATA_WIDTH-1:0]}
- busy  out  1  packet in progress
- pkt_done  out  1  one-cycle pulse after the tail flit is written

Behaviour:
- Reset (synchronous, active-high): state=IDLE, remaining=0, busy=0, pkt_done=0. req_ready=1, data_ready=0, wr_en=0, flit_out=0 in the cycle after reset.
- FSM states: IDLE, HEADER, PAYLOAD.
- IDLE
  - req_ready=1.
  - On req_valid: latch dst and len, then go to HEADER next cycle.
  - Latched len = req_len, except req_len==0, which is latched as 1. Every packet is at least header+tail.
- HEADER
  - flit_out = {3'b001, hdr}, wr_en = ~full.
  - hdr bit layout: [ADDR_WIDTH-1:0]=dst; [2*ADDR_WIDTH-1:ADDR_WIDTH]=SRC_ADDR; [2*ADDR_WIDTH+LEN_WIDTH-1:2*ADDR_WIDTH]=len; remaining upper bits 0.
  - On a cycle with ~full: header is written, remaining=len, go to PAYLOAD.
  - While full=1: hold state, wr_en=0.
- PAYLOAD
  - data_ready = ~full. It does not depend on data_valid (no combinational loop).
  - wr_en = data_valid & ~full.
  - flit_out = {type, data_in}, where type=100 if remaining==1, else 010.
  - On each write: remaining decrements. When the written flit is the tail, go to IDLE and assert pkt_done=1 on the next cycle only.
  - Stalls on full or ~data_valid hold all state. No flit is dropped or duplicated.
- Output timing:
  - wr_en and flit_out are combinational from registered state, latched fields and data_in.
  - The FIFO samples them on the same clk edge, so a header is written in the first HEADER cycle when full=0. Request-to-header latency is 1 cycle.
- busy=1 in HEADER and PAYLOAD.
- req_ready=0 outside IDLE. Back-to-back packets therefore insert exactly one IDLE cycle between a tail and the next header.
- Width rules:
  - remaining is LEN_WIDTH bits; max len 2^LEN_WIDTH-1 with no wrap.
  - Decrement occurs only on a write, and never below 1 before the tail.
- Simultaneous events:
  - full rising in the same cycle as data_valid: no write, data_ready=0, word held by the source.
  - req_valid while busy is ignored (req_ready=0).
- Reset mid-packet: abort immediately to IDLE. No tail is emitted. The partial packet is recovered by the system-wide reset of FIFO and router.
- wr_en is never asserted while full=1.

Test Plan:
- Reset, then req_dst=3, req_len=2 with data 0xA, 0xB always valid and full=0 → header in cycle 1 after acceptance with flit_type=001 and dst=3/src=0/len=2 fields; then 010/0xA; then 100/0xB; pkt_done pulses once; busy drops.
- req_len=0 → header with len field=1; the single data word is sent as tail 100; total 2 writes.
- full=1 held for 5 cycles during HEADER and mid-PAYLOAD → wr_en=0 and data_ready=0 throughout; the flit sequence after release matches the no-stall case exactly, with no loss or duplication.
- data_valid toggling 1,0,1,0 with len=4 → exactly 4 payload writes, types 010,010,010,100 in order.
- Two back-to-back requests (req_valid held) → second header written exactly 2 cycles after the first tail (1 IDLE accept cycle); req_ready=0 during packet 1.
- Assert rst in the 2nd body flit of a len=5 packet → next cycle state is IDLE, wr_en=0, req_ready=1, pkt_done=0, and no tail emitted.
